capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Capture controller for the scope acquisition path. It is the consumer side of the trigger handshake: it fills the sample RAM in a circular buffer and raises `armed` once enough pre-trigger samples are stored. After `trigger` is seen it counts the post-trigger samples, then pulses `set_capture_done`, which clears the trigger latch. It also drives the RAM write strobe and address, and reports where the trace ends.

## Interface
- `ADDR_W`, 9: sample RAM address width; DEPTH = 2**ADDR_W.
- `DEC_W`, 4: width of the decimation exponent.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `capture_en` in 1: start request; sampled in IDLE and DONE.
- `done_clr` in 1: acknowledge of a finished capture; DONE -> IDLE.
- `trig_pos` in ADDR_W: number of post-trigger samples; effective value `tp = min(trig_pos, DEPTH-1)`.
- `decimator` in DEC_W: write one sample every 2**decimator clocks.
- `trigger` in 1: latched trigger flag from the trigger block.
- `armed` out 1: pre-trigger fill is complete; trigger is permitted.
- `set_capture_done` out 1: one-cycle pulse at capture end.
- `capture_done` out 1: high for the whole time the block is in DONE.
- `we` out 1: RAM write enable.
- `waddr` out ADDR_W: RAM write address.
- `trace_end` out ADDR_W: address of the last sample written in the most recent capture.

## Operation
- States: IDLE, WAIT_TRIG, POST_TRIG, DONE.
- **Decimation counter `dec_cnt`**:
  - Held at 0 in IDLE and DONE; otherwise counts 0..2**decimator-1 and wraps.
  - `tick = (dec_cnt == 2**decimator-1)`. With `decimator = 0`, `tick` is high every cycle.
- **Write rule:**
  - `we = tick && state ∈ {WAIT_TRIG, POST_TRIG}`.
  - `waddr` increments modulo DEPTH on every `we`.
- **IDLE:**
  - If `capture_en`: go to WAIT_TRIG, clear `waddr`, `smpl_cnt`, `post_cnt` and `dec_cnt`.
- **WAIT_TRIG:**
  - `smpl_cnt` increments on `we` and saturates at DEPTH.
  - `armed = (state == WAIT_TRIG) && (smpl_cnt >= DEPTH - tp)`; decoded from registered state with no extra register stage.
  - If `trigger && armed`:
    - `tp == 0`: go to DONE.
    - Otherwise go to POST_TRIG with `post_cnt = 0`.
  - `trigger` without `armed` is ignored.
- **POST_TRIG:**
  - `post_cnt` increments on `we`.
  - On the `we` where `post_cnt == tp-1`: go to DONE.
- **DONE:**
  - `set_capture_done` is high in the first DONE cycle only.
  - `trace_end` is loaded on entry as `waddr - 1` mod DEPTH, i.e. the last written address. It holds until the next entry to DONE.
  - `capture_done = 1` throughout DONE.
  - `done_clr` -> IDLE.
  - `capture_en` -> WAIT_TRIG, with the same clears as from IDLE. `capture_en` wins if `done_clr` and `capture_en` are both high.
- **Ignored inputs:** `capture_en` in WAIT_TRIG or POST_TRIG; `done_clr` outside DONE.
- **Mid-capture input changes:**
  - `trig_pos` and `decimator` are not registered.
  - Changing either mid-capture takes effect immediately. This is legal and must not hang the block.
  - A `post_cnt` already past `tp-1` finishes when `post_cnt` wraps; no guard is added.

## Timing
- **Reset values:**
  - state = IDLE.
  - `dec_cnt`, `smpl_cnt`, `post_cnt`, `waddr` and `trace_end` = 0.
  - All outputs 0.
  - Reset mid-capture aborts with no further `we`.
- **Capture start:** `capture_en` high at edge N -> WAIT_TRIG from N+1. With `decimator = 0`, the first `we` is in cycle N+1 at `waddr = 0`.
- **Arming:** `armed` rises in the cycle after the (DEPTH - tp)-th write.
- **Trigger to POST_TRIG:** `trigger` and `armed` high at edge M -> POST_TRIG from M+1.
- **Capture end:** the final write occurs in cycle K -> DONE and `set_capture_done` in cycle K+1. `armed` is already 0 at that point.
- **Trigger latch release:** the trigger block clears `trigger` at K+2.
- **Write count:** exactly `tp` writes occur after the trigger state change; none occur in DONE.

## Structure
- **Package `capture_pkg`:**
  - `typedef enum logic [1:0] {IDLE, WAIT_TRIG, POST_TRIG, DONE} cap_state_t`.
  - Helper function `depth(aw)`.
- **Sub-module `sample_decimator`:**
  - Ports: `clk`, `rst`, `run`, `decimator` -> `tick`.
  - Holds `dec_cnt`; clears `dec_cnt` when `run` is low.
- **Top level:** state machine, address/sample/post counters and output decode.

## Test plan
All scenarios use `ADDR_W = 4` (DEPTH 16).
- **Basic capture:** `decimator = 0`, `trig_pos = 6`; pulse `capture_en`.
  - `armed` rises after 10 writes.
  - Assert `trigger` 5 cycles later -> exactly 6 further writes.
  - `set_capture_done` pulses once; `trace_end = waddr - 1`.
- **Decimation:** `decimator = 2` -> `we` every 4th cycle; `waddr` steps 0, 1, 2, …; no `we` in IDLE/DONE.
- **Wrap-around:** `trig_pos = 2`, trigger withheld for 40 writes -> `waddr` wraps 15 -> 0.
  - `smpl_cnt` saturates at 16.
  - After trigger, `trace_end = (40 + 2 - 1) mod 16 = 9`.
- **Boundaries:**
  - `trig_pos = 0`: trigger -> DONE the next cycle with zero post-trigger writes.
  - `trig_pos = 20`: clamped to 15, so `armed` after 1 write.
- **Trigger gating:** `trigger` high before `armed` -> stays in WAIT_TRIG; once `armed` rises it is taken the next cycle.
- **Control collisions:**
  - `capture_en` in POST_TRIG is ignored.
  - `done_clr` + `capture_en` together in DONE -> WAIT_TRIG with `waddr = 0`.
  - `rst` in POST_TRIG -> IDLE with all outputs 0 on the next cycle.

Source files
------------

// File: rtl/capture_ctrl_pkg.sv
// Shared types and helpers for the scope capture controller.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        POST_TRIG = 2'd2,
        DONE      = 2'd3
    } cap_state_t;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Trigger handshake and sample-RAM write port between the capture controller and its peers.
interface capture_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              trigger;
    logic              armed;
    logic              set_capture_done;
    logic              we;
    logic [ADDR_W-1:0] waddr;

    modport master (
        input  trigger,
        output armed,
        output set_capture_done,
        output we,
        output waddr
    );

    modport slave (
        output trigger,
        input  armed,
        input  set_capture_done,
        input  we,
        input  waddr
    );
endinterface

// File: rtl/capture_ctrl_sample_decimator.sv
// Sample-rate divider: tick once every 2**decimator clocks while run is high.
module sample_decimator #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DEC_W-1:0] decimator,
    output logic             tick
);
    localparam int CNT_W = (1 << DEC_W) - 1;

    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d, limit;

    always_comb begin
        limit = (CNT_W'(1) << decimator) - CNT_W'(1);
        // >= lets a decimator shrunk mid-capture tick at once instead of waiting for a counter wrap
        tick      = (dec_cnt_q >= limit);
        dec_cnt_d = (!run || tick) ? '0 : dec_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt_q <= '0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
        end
    end
endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: circular pre-trigger fill, arming, post-trigger count and trace end report.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    capture_ctrl_if.master    bus,
    input  logic              capture_en,
    input  logic              done_clr,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [DEC_W-1:0]  decimator,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trace_end
);
    localparam int DEPTH = depth(ADDR_W);
    localparam int CNT_W = ADDR_W + 1;

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trace_end_q, trace_end_d;
    logic [CNT_W-1:0]  smpl_cnt_q, smpl_cnt_d;
    logic              set_capture_done_q, set_capture_done_d;
    logic              run, tick, we, armed;
    logic [ADDR_W-1:0] tp;
    logic [CNT_W-1:0]  arm_level;

    sample_decimator #(.DEC_W(DEC_W)) u_dec (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .decimator (decimator),
        .tick      (tick)
    );

    // trig_pos is ADDR_W wide, so it can never exceed DEPTH-1 and the clamp is implicit
    assign tp        = trig_pos;
    assign arm_level = CNT_W'(DEPTH) - CNT_W'(tp);
    assign run       = (state_q == WAIT_TRIG) || (state_q == POST_TRIG);
    assign we        = tick && run;
    assign armed     = (state_q == WAIT_TRIG) && (smpl_cnt_q >= arm_level);

    always_comb begin
        state_d            = state_q;
        waddr_d            = waddr_q;
        post_cnt_d         = post_cnt_q;
        smpl_cnt_d         = smpl_cnt_q;
        trace_end_d        = trace_end_q;
        set_capture_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_en) begin
                    state_d    = WAIT_TRIG;
                    waddr_d    = '0;
                    smpl_cnt_d = '0;
                    post_cnt_d = '0;
                end
            end
            WAIT_TRIG: begin
                if (we) begin
                    waddr_d = waddr_q + ADDR_W'(1);
                    if (smpl_cnt_q != CNT_W'(DEPTH)) smpl_cnt_d = smpl_cnt_q + CNT_W'(1);
                end
                if (bus.trigger && armed) begin
                    post_cnt_d = '0;
                    state_d    = (tp == '0) ? DONE : POST_TRIG;
                end
            end
            POST_TRIG: begin
                if (we) begin
                    waddr_d    = waddr_q + ADDR_W'(1);
                    post_cnt_d = post_cnt_q + ADDR_W'(1);
                    if (post_cnt_q == tp - ADDR_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (capture_en) begin
                    state_d    = WAIT_TRIG;
                    waddr_d    = '0;
                    smpl_cnt_d = '0;
                    post_cnt_d = '0;
                end else if (done_clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // waddr_d already includes the final write, so one behind it is the last written address
        if (state_d == DONE && state_q != DONE) begin
            set_capture_done_d = 1'b1;
            trace_end_d        = waddr_d - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            waddr_q            <= '0;
            post_cnt_q         <= '0;
            smpl_cnt_q         <= '0;
            trace_end_q        <= '0;
            set_capture_done_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            waddr_q            <= waddr_d;
            post_cnt_q         <= post_cnt_d;
            smpl_cnt_q         <= smpl_cnt_d;
            trace_end_q        <= trace_end_d;
            set_capture_done_q <= set_capture_done_d;
        end
    end

    assign bus.we               = we;
    assign bus.waddr            = waddr_q;
    assign bus.armed            = armed;
    assign bus.set_capture_done = set_capture_done_q;
    assign capture_done         = (state_q == DONE);
    assign trace_end            = trace_end_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected write addresses queued per capture, checked on every we.
module tb_capture_ctrl;
    localparam int ADDR_W = 4;
    localparam int DEC_W  = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              capture_en;
    logic              done_clr;
    logic [ADDR_W-1:0] trig_pos;
    logic [DEC_W-1:0]  decimator;
    logic              capture_done;
    logic [ADDR_W-1:0] trace_end;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int exp_q[$];
    int n;

    capture_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    capture_ctrl #(.ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .capture_en   (capture_en),
        .done_clr     (done_clr),
        .trig_pos     (trig_pos),
        .decimator    (decimator),
        .capture_done (capture_done),
        .trace_end    (trace_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // every write strobe must match the next queued address
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (exp_q.size() == 0) check("we_extra", bus.we, 0);
            else check("waddr", bus.waddr, exp_q.pop_front());
            wr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_writes(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back((first + i) % DEPTH);
    endtask

    task automatic start_capture();
        wr_cnt     = 0;
        capture_en = 1'b1;
        step();
        capture_en = 1'b0;
    endtask

    task automatic wait_armed(input int max, output int cyc);
        cyc = 0;
        while (!bus.armed && cyc < max) begin
            step();
            cyc++;
        end
        if (!bus.armed) check("armed_timeout", bus.armed, 1);
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!bus.set_capture_done && cyc < max) begin
            step();
            cyc++;
        end
        if (!bus.set_capture_done) check("done_timeout", bus.set_capture_done, 1);
    endtask

    task automatic end_checks(input string tag, input int exp_trace, input int exp_wr);
        check({tag, "_set_done"}, bus.set_capture_done, 1);
        check({tag, "_cap_done"}, capture_done, 1);
        check({tag, "_armed_low"}, bus.armed, 0);
        check({tag, "_trace_end"}, trace_end, exp_trace);
        check({tag, "_writes"}, wr_cnt, exp_wr);
        check({tag, "_queue"}, exp_q.size(), 0);
        bus.trigger = 1'b0;
        step();
        check({tag, "_pulse_once"}, bus.set_capture_done, 0);
        check({tag, "_done_hold"}, capture_done, 1);
        repeat (3) step();
    endtask

    task automatic clear_done(input string tag);
        done_clr = 1'b1;
        step();
        done_clr = 1'b0;
        check({tag, "_idle"}, capture_done, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, bus.we, 0);
        check({tag, "_waddr"}, bus.waddr, 0);
        check({tag, "_armed"}, bus.armed, 0);
        check({tag, "_set_done"}, bus.set_capture_done, 0);
        check({tag, "_cap_done"}, capture_done, 0);
        check({tag, "_trace_end"}, trace_end, 0);
    endtask

    initial begin
        rst         = 1'b1;
        capture_en  = 1'b0;
        done_clr    = 1'b0;
        trig_pos    = '0;
        decimator   = '0;
        bus.trigger = 1'b0;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // basic: armed after 10 writes, trigger 5 cycles later, 6 post writes
        decimator = 4'd0; trig_pos = 4'd6;
        push_writes(0, 16); push_writes(0, 6);
        start_capture();
        wait_armed(50, n);
        check("basic_arm_cycles", n, 10);
        check("basic_arm_writes", wr_cnt, 10);
        repeat (5) step();
        bus.trigger = 1'b1;
        step();
        check("basic_post_armed", bus.armed, 0);
        wait_done(50, n);
        check("basic_post_cycles", n, 6);
        end_checks("basic", 5, 22);
        clear_done("basic");

        // decimation by 4
        decimator = 4'd2; trig_pos = 4'd6;
        push_writes(0, 16);
        start_capture();
        wait_armed(200, n);
        check("dec_arm_cycles", n, 40);
        check("dec_arm_writes", wr_cnt, 10);
        bus.trigger = 1'b1;
        step();
        wait_done(200, n);
        check("dec_post_cycles", n, 23);
        end_checks("dec", 15, 16);
        clear_done("dec");

        // wrap-around with the trigger withheld for 40 writes
        decimator = 4'd0; trig_pos = 4'd2;
        push_writes(0, 32); push_writes(0, 10);
        start_capture();
        repeat (39) step();
        check("wrap_armed", bus.armed, 1);
        bus.trigger = 1'b1;
        step();
        wait_done(20, n);
        check("wrap_post_cycles", n, 2);
        end_checks("wrap", 9, 42);
        clear_done("wrap");

        // zero post-trigger samples
        trig_pos = 4'd0;
        push_writes(0, 17);
        start_capture();
        wait_armed(50, n);
        check("tp0_arm_cycles", n, 16);
        bus.trigger = 1'b1;
        step();
        end_checks("tp0", 0, 17);
        clear_done("tp0");

        // largest trig_pos: armed after one write
        trig_pos = 4'd15;
        push_writes(0, 17);
        start_capture();
        wait_armed(50, n);
        check("tpmax_arm_cycles", n, 1);
        bus.trigger = 1'b1;
        step();
        wait_done(50, n);
        check("tpmax_post_cycles", n, 15);
        end_checks("tpmax", 0, 17);
        clear_done("tpmax");

        // trigger held high from IDLE onwards is only taken once armed
        trig_pos = 4'd6;
        bus.trigger = 1'b1;
        repeat (2) step();
        check("gate_idle", capture_done, 0);
        push_writes(0, 17);
        start_capture();
        wait_armed(50, n);
        check("gate_arm_cycles", n, 10);
        step();
        check("gate_taken", bus.armed, 0);
        wait_done(50, n);
        check("gate_post_cycles", n, 6);
        end_checks("gate", 0, 17);
        clear_done("gate");

        // capture_en in POST_TRIG ignored
        trig_pos = 4'd4;
        push_writes(0, 16); push_writes(0, 3);
        start_capture();
        wait_armed(50, n);
        check("coll_arm_cycles", n, 12);
        repeat (2) step();
        bus.trigger = 1'b1;
        step();
        capture_en = 1'b1;
        step();
        capture_en = 1'b0;
        wait_done(50, n);
        check("coll_post_cycles", n, 3);
        end_checks("coll", 2, 19);

        // done_clr and capture_en together restart the capture
        push_writes(0, 14);
        wr_cnt     = 0;
        capture_en = 1'b1;
        done_clr   = 1'b1;
        step();
        capture_en = 1'b0;
        done_clr   = 1'b0;
        check("restart_cap_done", capture_done, 0);
        check("restart_waddr", bus.waddr, 0);
        check("restart_we", bus.we, 1);
        wait_armed(50, n);
        check("restart_arm_cycles", n, 12);
        check("restart_trace_hold", trace_end, 2);
        bus.trigger = 1'b1;
        step();
        check("restart_post", bus.armed, 0);

        // reset in POST_TRIG aborts the capture
        rst = 1'b1;
        bus.trigger = 1'b0;
        step();
        check_zero("abort");
        rst = 1'b0;
        repeat (3) step();
        check("abort_writes", wr_cnt, 14);
        check("abort_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
